// File: rtl/plasma_gpio_pkg.sv
// Shared definitions for the Plasma GPIO peripheral: register word indices
// and the debounce counter width helper.
package plasma_gpio_pkg;

  localparam logic [2:0] GPIO_REG_OUT      = 3'd0;
  localparam logic [2:0] GPIO_REG_OUT_SET  = 3'd1;
  localparam logic [2:0] GPIO_REG_OUT_CLR  = 3'd2;
  localparam logic [2:0] GPIO_REG_IN       = 3'd3;
  localparam logic [2:0] GPIO_REG_EDGE     = 3'd4;
  localparam logic [2:0] GPIO_REG_IRQ_MASK = 3'd5;
  localparam logic [2:0] GPIO_REG_RISE_EN  = 3'd6;
  localparam logic [2:0] GPIO_REG_FALL_EN  = 3'd7;

  // Counter must hold 0..cycles-1; a zero-width counter is not legal.
  function automatic int gpio_cnt_width(input int cycles);
    return (cycles > 32'sd2) ? $clog2(cycles) : 32'sd1;
  endfunction

endpackage

// File: rtl/plasma_gpio_debounce.sv
// One input bit: multi-flop synchroniser followed by a stability counter.
// rise/fall pulse on the same edge that the accepted value changes.
module plasma_gpio_debounce
  import plasma_gpio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int            CW       = gpio_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CW-1:0]          cnt_r;
  logic                   stable_r;
  logic                   s_s;
  logic                   accept_s;

  assign s_s      = sync_r[SYNC_STAGES-1];
  assign accept_s = (s_s != stable_r) && (cnt_r == CNT_LAST);

  // Synchroniser shift chain and debounce counter / accepted value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r   <= '0;
      cnt_r    <= '0;
      stable_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      if (s_s == stable_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        stable_r <= s_s;
        cnt_r    <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign stable = stable_r;
  assign rise   = accept_s & s_s;
  assign fall   = accept_s & ~s_s;

endmodule

// File: rtl/plasma_gpio_irq.sv
// Avalon-MM GPIO peripheral for the Plasma SoC: output register with
// set/clear aliases, debounced inputs with edge capture, masked level IRQ.
module plasma_gpio_irq
  import plasma_gpio_pkg::*;
#(
  parameter int               N_OUT           = 10,
  parameter int               N_IN            = 10,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter logic [N_OUT-1:0] OUT_RESET       = '0
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic [N_OUT-1:0] gpio_out,
  input  logic [N_IN-1:0]  gpio_in,
  output logic             irq
);

  logic [N_OUT-1:0] out_r;
  logic [N_IN-1:0]  edge_r;
  logic [N_IN-1:0]  mask_r;
  logic [N_IN-1:0]  rise_en_r;
  logic [N_IN-1:0]  fall_en_r;
  logic [31:0]      readdata_r;
  logic             irq_r;

  logic [N_IN-1:0]  stable_s;
  logic [N_IN-1:0]  rise_s;
  logic [N_IN-1:0]  fall_s;
  logic [N_OUT-1:0] wdata_out_s;
  logic [N_IN-1:0]  wdata_in_s;
  logic [N_OUT-1:0] out_next_s;
  logic [N_IN-1:0]  w1c_s;
  logic [N_IN-1:0]  edge_set_s;
  logic [N_IN-1:0]  edge_next_s;
  logic [31:0]      rd_data_s;
  logic             unused_wdata_s;

  assign wdata_out_s    = avs_writedata[N_OUT-1:0];
  assign wdata_in_s     = avs_writedata[N_IN-1:0];
  assign unused_wdata_s = ^avs_writedata;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    plasma_gpio_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .din   (gpio_in[i]),
      .stable(stable_s[i]),
      .rise  (rise_s[i]),
      .fall  (fall_s[i])
    );
  end

  // Next-state for the output register and the edge capture bits.
  always_comb begin
    out_next_s = out_r;
    w1c_s      = '0;
    if (avs_write) begin
      case (avs_address)
        GPIO_REG_OUT:     out_next_s = wdata_out_s;
        GPIO_REG_OUT_SET: out_next_s = out_r | wdata_out_s;
        GPIO_REG_OUT_CLR: out_next_s = out_r & ~wdata_out_s;
        GPIO_REG_EDGE:    w1c_s      = wdata_in_s;
        default:          out_next_s = out_r;
      endcase
    end else begin
      out_next_s = out_r;
    end
    // A capture in the same cycle as a clear must survive.
    edge_set_s  = (rise_s & rise_en_r) | (fall_s & fall_en_r);
    edge_next_s = (edge_r & ~w1c_s) | edge_set_s;
  end

  // Read mux: write-only and unused bits return zero.
  always_comb begin
    rd_data_s = 32'd0;
    case (avs_address)
      GPIO_REG_OUT:      rd_data_s = 32'(out_r);
      GPIO_REG_IN:       rd_data_s = 32'(stable_s);
      GPIO_REG_EDGE:     rd_data_s = 32'(edge_r);
      GPIO_REG_IRQ_MASK: rd_data_s = 32'(mask_r);
      GPIO_REG_RISE_EN:  rd_data_s = 32'(rise_en_r);
      GPIO_REG_FALL_EN:  rd_data_s = 32'(fall_en_r);
      default:           rd_data_s = 32'd0;
    endcase
  end

  // Register file, read data capture and interrupt level.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      out_r      <= OUT_RESET;
      edge_r     <= '0;
      mask_r     <= '0;
      rise_en_r  <= '0;
      fall_en_r  <= '0;
      readdata_r <= 32'd0;
      irq_r      <= 1'b0;
    end else begin
      out_r  <= out_next_s;
      edge_r <= edge_next_s;
      irq_r  <= |(edge_r & mask_r);
      if (avs_write) begin
        case (avs_address)
          GPIO_REG_IRQ_MASK: mask_r    <= wdata_in_s;
          GPIO_REG_RISE_EN:  rise_en_r <= wdata_in_s;
          GPIO_REG_FALL_EN:  fall_en_r <= wdata_in_s;
          default:           mask_r    <= mask_r;
        endcase
      end
      if (avs_read) begin
        readdata_r <= rd_data_s;
      end
    end
  end

  assign avs_readdata = readdata_r;
  assign gpio_out     = out_r;
  assign irq          = irq_r;

endmodule
